// File: rtl/csh_cyc_pkg.sv
// Shared types and helpers for the cache cycle arbiter/sequencer.
package csh_cyc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOOKUP  = 4'd1,
        ST_HIT_RD  = 4'd2,
        ST_HIT_WR  = 4'd3,
        ST_WB      = 4'd4,
        ST_CORE_RD = 4'd5,
        ST_FILL    = 4'd6,
        ST_UNC     = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } cyc_state_t;

    localparam int DIAG_ST_W  = 4;
    localparam int DIAG_GNT_W = 4;
    localparam int DIAG_W     = DIAG_ST_W + DIAG_GNT_W;

    // Index width that never collapses to zero bits, so 1-entry configs still get a port.
    function automatic int clog2min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csh_rr_arb.sv
// One-hot requester arbiter: fixed priority (index 0 wins) or round robin from a pointer.
module csh_rr_arb
    import csh_cyc_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2min1(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_rr_mode,
    input  logic            i_take,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    // Scan from the pointer (round robin) or from 0 (fixed) for the first active request.
    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (i_rr_mode ? int'(r_ptr) : 0) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

    // Pointer moves past the winner only when a round-robin grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_take && i_rr_mode) begin
            r_ptr <= (o_idx == IW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/csh_cyc_arb.sv
// Cache request arbiter and single-cycle-at-a-time cache cycle sequencer.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no cycle; arbitrate and latch a winner
//   LOOKUP  | evaluate tag match, cacheability and abort
//   HIT_RD  | read hit; update use bits
//   HIT_WR  | write hit; write data RAM and update use bits
//   WB      | write dirty victim line to core, one word per beat
//   CORE_RD | request line from core, wait for first beat
//   FILL    | write refill beats into the victim way
//   UNC     | single uncached core read or write
//   DONE    | one-clock completion pulse, clear cycle context
//   ERR     | multi-match or core timeout; drop core requests
module csh_cyc_arb
    import csh_cyc_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NWAYS = 4,
    parameter  int WPL   = 4,
    parameter  int TMO   = 1023,
    localparam int IW    = clog2min1(NREQ),
    localparam int WW    = clog2min1(NWAYS),
    localparam int CW    = clog2min1(WPL),
    localparam int TW    = $clog2(TMO + 1),
    localparam int MW    = $clog2(NWAYS + 1)
) (
    input  logic              clk_csh_h,
    input  logic              mr_reset_l,
    input  logic [NREQ-1:0]   req_h,
    input  logic [NREQ-1:0]   req_wr_h,
    input  logic              rr_mode_h,
    output logic [NREQ-1:0]   grant_h,
    output logic              cyc_busy_h,
    input  logic [NWAYS-1:0]  valid_match_h,
    input  logic [NWAYS-1:0]  any_wr_h,
    input  logic [WW-1:0]     lru_way_h,
    input  logic              cache_bit_h,
    input  logic              abort_h,
    output logic              core_rd_rq_h,
    output logic              core_wr_rq_h,
    input  logic              core_data_valid_h,
    output logic              cache_wr_h,
    output logic [WW-1:0]     way_sel_h,
    output logic [CW-1:0]     word_cnt_h,
    output logic              use_wr_en_h,
    output logic              done_h,
    output logic              hit_h,
    output logic              err_h,
    input  logic              diag_rd_h,
    output logic [DIAG_W-1:0] diag_data_h
);

    cyc_state_t      r_state, w_state_nx;
    logic [NREQ-1:0] r_grant, w_grant_nx;
    logic [IW-1:0]   r_gidx, w_gidx_nx;
    logic            r_wr, w_wr_nx;
    logic [WW-1:0]   r_way, w_way_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [TW-1:0]   r_tmo, w_tmo_nx;
    logic            r_hit, w_hit_nx;
    logic            r_err, w_err_nx;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic            w_take;
    logic [MW-1:0]   w_nmatch;
    logic [WW-1:0]   w_match_way;
    logic            w_tmo_run;
    logic            w_tmo_hit;
    logic            w_last_word;

    csh_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk       (clk_csh_h),
        .rst_n     (mr_reset_l),
        .i_req     (req_h),
        .i_rr_mode (rr_mode_h),
        .i_take    (w_take),
        .o_gnt     (w_arb_gnt),
        .o_idx     (w_arb_idx)
    );

    // Count tag matches and remember the (single) matching way.
    always_comb begin
        w_nmatch    = '0;
        w_match_way = '0;
        for (int k = 0; k < NWAYS; k++) begin
            if (valid_match_h[k]) begin
                w_nmatch    = w_nmatch + 1'b1;
                w_match_way = WW'(k);
            end
        end
    end

    assign w_tmo_run   = (r_state == ST_WB) || (r_state == ST_CORE_RD) ||
                         (r_state == ST_FILL) || (r_state == ST_UNC);
    assign w_tmo_hit   = w_tmo_run && !core_data_valid_h && (r_tmo == TW'(TMO - 1));
    assign w_last_word = (r_cnt == CW'(WPL - 1));

    // Next-state, cycle context and per-clock strobes.
    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_gidx_nx    = r_gidx;
        w_wr_nx      = r_wr;
        w_way_nx     = r_way;
        w_cnt_nx     = r_cnt;
        w_hit_nx     = r_hit;
        w_err_nx     = r_err;
        w_tmo_nx     = '0;
        w_take       = 1'b0;
        cache_wr_h   = 1'b0;
        use_wr_en_h  = 1'b0;
        core_rd_rq_h = 1'b0;
        core_wr_rq_h = 1'b0;

        // Timer restarts on every core beat and is held at 0 outside core-wait states.
        if (w_tmo_run && !core_data_valid_h) w_tmo_nx = r_tmo + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (|req_h) begin
                    w_take     = 1'b1;
                    w_grant_nx = w_arb_gnt;
                    w_gidx_nx  = w_arb_idx;
                    w_wr_nx    = |(w_arb_gnt & req_wr_h);
                    w_state_nx = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (abort_h) begin
                    w_state_nx = ST_DONE;
                end else if (w_nmatch > MW'(1)) begin
                    w_state_nx = ST_ERR;
                end else if (!cache_bit_h) begin
                    w_state_nx = ST_UNC;
                end else if (w_nmatch == MW'(1)) begin
                    w_way_nx   = w_match_way;
                    w_state_nx = r_wr ? ST_HIT_WR : ST_HIT_RD;
                end else begin
                    w_way_nx   = lru_way_h;
                    w_state_nx = any_wr_h[lru_way_h] ? ST_WB : ST_CORE_RD;
                end
            end
            ST_HIT_RD: begin
                use_wr_en_h = 1'b1;
                w_hit_nx    = 1'b1;
                w_state_nx  = ST_DONE;
            end
            ST_HIT_WR: begin
                cache_wr_h  = 1'b1;
                use_wr_en_h = 1'b1;
                w_hit_nx    = 1'b1;
                w_state_nx  = ST_DONE;
            end
            ST_WB: begin
                core_wr_rq_h = 1'b1;
                if (core_data_valid_h) begin
                    if (w_last_word) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_CORE_RD;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_ERR;
                end
            end
            ST_CORE_RD: begin
                core_rd_rq_h = 1'b1;
                // The first beat is refill word 0 and is written in this same clock.
                if (core_data_valid_h) begin
                    cache_wr_h = 1'b1;
                    if (w_last_word) begin
                        use_wr_en_h = 1'b1;
                        w_cnt_nx    = '0;
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_cnt_nx   = r_cnt + 1'b1;
                        w_state_nx = ST_FILL;
                    end
                end else if (abort_h) begin
                    w_state_nx = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_ERR;
                end
            end
            ST_FILL: begin
                if (core_data_valid_h) begin
                    cache_wr_h = 1'b1;
                    if (w_last_word) begin
                        use_wr_en_h = 1'b1;
                        w_cnt_nx    = '0;
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_ERR;
                end
            end
            ST_UNC: begin
                core_wr_rq_h = r_wr;
                core_rd_rq_h = !r_wr;
                if (core_data_valid_h) begin
                    w_state_nx = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_ERR;
                end
            end
            ST_ERR: begin
                w_err_nx   = 1'b1;
                w_state_nx = ST_DONE;
            end
            ST_DONE: begin
                w_grant_nx = '0;
                w_gidx_nx  = '0;
                w_wr_nx    = 1'b0;
                w_way_nx   = '0;
                w_cnt_nx   = '0;
                w_hit_nx   = 1'b0;
                w_err_nx   = 1'b0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and cycle-context registers.
    always_ff @(posedge clk_csh_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_wr    <= 1'b0;
            r_way   <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_gidx  <= w_gidx_nx;
            r_wr    <= w_wr_nx;
            r_way   <= w_way_nx;
            r_cnt   <= w_cnt_nx;
            r_tmo   <= w_tmo_nx;
            r_hit   <= w_hit_nx;
            r_err   <= w_err_nx;
        end
    end

    assign grant_h     = r_grant;
    assign cyc_busy_h  = (r_state != ST_IDLE);
    assign way_sel_h   = r_way;
    assign word_cnt_h  = r_cnt;
    assign done_h      = (r_state == ST_DONE);
    assign hit_h       = done_h & r_hit;
    assign err_h       = done_h & r_err;
    assign diag_data_h = diag_rd_h ? {DIAG_ST_W'(r_state), DIAG_GNT_W'(r_gidx)} : '0;

endmodule

// File: tb/tb_csh_cyc_arb.sv
// Scoreboard bench for csh_cyc_arb (4 requesters, 4 ways, 4 words/line, short timeout).
module tb_csh_cyc_arb;

    logic       clk_csh_h = 1'b0;
    logic       mr_reset_l;
    logic [3:0] req_h, req_wr_h;
    logic       rr_mode_h;
    logic [3:0] grant_h;
    logic       cyc_busy_h;
    logic [3:0] valid_match_h, any_wr_h;
    logic [1:0] lru_way_h;
    logic       cache_bit_h, abort_h;
    logic       core_rd_rq_h, core_wr_rq_h, core_data_valid_h;
    logic       cache_wr_h;
    logic [1:0] way_sel_h, word_cnt_h;
    logic       use_wr_en_h, done_h, hit_h, err_h, diag_rd_h;
    logic [7:0] diag_data_h;

    typedef struct {
        logic [3:0] grant;
        logic       hit;
        logic       err;
        logic [1:0] way;
        int         n_wr;
        int         n_use;
        int         n_wbb;
        int         n_rdq;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_wr, m_use, m_wbb, m_rdq;
    logic prev_done;
    int   lat;

    csh_cyc_arb #(.NREQ(4), .NWAYS(4), .WPL(4), .TMO(8)) dut (
        .clk_csh_h         (clk_csh_h),
        .mr_reset_l        (mr_reset_l),
        .req_h             (req_h),
        .req_wr_h          (req_wr_h),
        .rr_mode_h         (rr_mode_h),
        .grant_h           (grant_h),
        .cyc_busy_h        (cyc_busy_h),
        .valid_match_h     (valid_match_h),
        .any_wr_h          (any_wr_h),
        .lru_way_h         (lru_way_h),
        .cache_bit_h       (cache_bit_h),
        .abort_h           (abort_h),
        .core_rd_rq_h      (core_rd_rq_h),
        .core_wr_rq_h      (core_wr_rq_h),
        .core_data_valid_h (core_data_valid_h),
        .cache_wr_h        (cache_wr_h),
        .way_sel_h         (way_sel_h),
        .word_cnt_h        (word_cnt_h),
        .use_wr_en_h       (use_wr_en_h),
        .done_h            (done_h),
        .hit_h             (hit_h),
        .err_h             (err_h),
        .diag_rd_h         (diag_rd_h),
        .diag_data_h       (diag_data_h)
    );

    always #5 clk_csh_h = ~clk_csh_h;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] g, input logic h, input logic e, input logic [1:0] w,
                            input int nw, input int nu, input int nb, input int nr);
        exp_t x;
        x.grant = g; x.hit = h; x.err = e; x.way = w;
        x.n_wr = nw; x.n_use = nu; x.n_wbb = nb; x.n_rdq = nr;
        exp_q.push_back(x);
    endtask

    task automatic set_in(input logic [3:0] vm, input logic [3:0] aw, input logic [1:0] lru,
                          input logic cb, input logic dv, input logic [3:0] rw);
        valid_match_h = vm; any_wr_h = aw; lru_way_h = lru;
        cache_bit_h = cb; core_data_valid_h = dv; req_wr_h = rw; abort_h = 1'b0;
    endtask

    // Called just after a rising edge in IDLE; returns just after the grant edge.
    task automatic start(input logic [3:0] r);
        req_h = r;
        @(posedge clk_csh_h); #1;
        req_h = '0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_csh_h);
            n++;
        end while (done_h !== 1'b1 && n < budget);
        if (done_h !== 1'b1) check_eq({tag, "_no_done"}, 32'(done_h), 32'd1);
    endtask

    task automatic end_cycle();
        @(posedge clk_csh_h); #1;
    endtask

    // Monitor: tally per-cycle activity and compare against the scoreboard at done_h.
    initial begin
        exp_t e;
        m_wr = 0; m_use = 0; m_wbb = 0; m_rdq = 0; prev_done = 1'b0;
        forever begin
            @(negedge clk_csh_h);
            if (mr_reset_l !== 1'b1) begin
                exp_q.delete();
                m_wr = 0; m_use = 0; m_wbb = 0; m_rdq = 0; prev_done = 1'b0;
            end else begin
                if (prev_done) check_eq("done_pulse", 32'(done_h), 32'd0);
                if (cache_wr_h === 1'b1) begin
                    check_eq("wr_word", 32'(word_cnt_h), 32'(m_wr));
                    if (exp_q.size() > 0) check_eq("wr_way", 32'(way_sel_h), 32'(exp_q[0].way));
                    m_wr++;
                end
                if (use_wr_en_h === 1'b1) m_use++;
                if (core_wr_rq_h === 1'b1 && core_data_valid_h === 1'b1) m_wbb++;
                if (core_rd_rq_h === 1'b1) m_rdq++;
                if (done_h === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_pending", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_grant", 32'(grant_h), 32'(e.grant));
                        check_eq("sb_hit", 32'(hit_h), 32'(e.hit));
                        check_eq("sb_err", 32'(err_h), 32'(e.err));
                        check_eq("sb_n_cache_wr", 32'(m_wr), 32'(e.n_wr));
                        check_eq("sb_n_use_wr", 32'(m_use), 32'(e.n_use));
                        check_eq("sb_n_wb_beats", 32'(m_wbb), 32'(e.n_wbb));
                        check_eq("sb_n_rd_rq_clks", 32'(m_rdq), 32'(e.n_rdq));
                    end
                    m_wr = 0; m_use = 0; m_wbb = 0; m_rdq = 0;
                end
                prev_done = done_h;
            end
        end
    end

    initial begin
        mr_reset_l = 1'b0;
        req_h = 4'hF; rr_mode_h = 1'b0; diag_rd_h = 1'b1;
        set_in(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 4'b0000);
        repeat (3) @(posedge clk_csh_h);
        @(negedge clk_csh_h);
        check_eq("rst_outs", {8'd0, grant_h, cyc_busy_h, core_rd_rq_h, core_wr_rq_h, cache_wr_h,
                 way_sel_h, word_cnt_h, use_wr_en_h, done_h, hit_h, err_h, diag_data_h}, 32'd0);
        req_h = '0; core_data_valid_h = 1'b0;
        @(posedge clk_csh_h); #1;
        mr_reset_l = 1'b1;
        end_cycle();

        // Fixed priority, read hit in way 2, grant latency and diag readout.
        set_in(4'b0100, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000);
        push_exp(4'b0010, 1'b1, 1'b0, 2'd2, 0, 1, 0, 0);
        req_h = 4'b1010;
        @(negedge clk_csh_h);
        check_eq("gnt_pre_edge", 32'(grant_h), 32'd0);
        @(negedge clk_csh_h);
        check_eq("gnt_fixed", 32'(grant_h), 32'b0010);
        check_eq("busy_lookup", 32'(cyc_busy_h), 32'd1);
        check_eq("diag_lookup", 32'(diag_data_h), 32'h11);
        req_h = '0; diag_rd_h = 1'b0;
        wait_done("hitrd", 10, lat);
        check_eq("hitrd_latency", 32'(lat), 32'd2);
        check_eq("diag_off", 32'(diag_data_h), 32'd0);
        end_cycle();

        // Round robin over all four requesters held active.
        rr_mode_h = 1'b1;
        set_in(4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000);
        push_exp(4'b0001, 1'b1, 1'b0, 2'd0, 0, 1, 0, 0);
        push_exp(4'b0010, 1'b1, 1'b0, 2'd0, 0, 1, 0, 0);
        push_exp(4'b0100, 1'b1, 1'b0, 2'd0, 0, 1, 0, 0);
        push_exp(4'b1000, 1'b1, 1'b0, 2'd0, 0, 1, 0, 0);
        push_exp(4'b0001, 1'b1, 1'b0, 2'd0, 0, 1, 0, 0);
        req_h = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done("rr", 10, lat);
            if (i == 4) req_h = '0;
            end_cycle();
            check_eq("rr_bubble", 32'(cyc_busy_h), 32'd0);
        end
        rr_mode_h = 1'b0;

        // Read miss, dirty victim way 2: writeback then refill.
        set_in(4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000);
        push_exp(4'b0001, 1'b0, 1'b0, 2'd2, 4, 1, 4, 1);
        start(4'b0001);
        wait_done("miss_wb", 40, lat);
        end_cycle();

        // Multi-match error.
        set_in(4'b0011, 4'b0000, 2'd0, 1'b1, 1'b1, 4'b0000);
        push_exp(4'b0001, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0);
        start(4'b0001);
        wait_done("multi", 10, lat);
        end_cycle();

        // Write hit in way 3.
        set_in(4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0100);
        push_exp(4'b0100, 1'b1, 1'b0, 2'd3, 1, 1, 0, 0);
        start(4'b0100);
        wait_done("hitwr", 10, lat);
        end_cycle();

        // Uncached write: single core write beat, no cache activity.
        set_in(4'b0000, 4'b1111, 2'd1, 1'b0, 1'b1, 4'b1000);
        push_exp(4'b1000, 1'b0, 1'b0, 2'd0, 0, 0, 1, 0);
        start(4'b1000);
        wait_done("unc_wr", 10, lat);
        end_cycle();

        // Core never answers: timeout after 8 clocks of read request.
        set_in(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000);
        push_exp(4'b0001, 1'b0, 1'b1, 2'd0, 0, 0, 0, 8);
        start(4'b0001);
        wait_done("timeout", 30, lat);
        check_eq("timeout_rq_drop", 32'(core_rd_rq_h), 32'd0);
        end_cycle();

        // Abort in LOOKUP ends the cycle with no writes.
        set_in(4'b0100, 4'b0000, 2'd0, 1'b1, 1'b1, 4'b0000);
        abort_h = 1'b1;
        push_exp(4'b0010, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0);
        start(4'b0010);
        wait_done("abort_lookup", 10, lat);
        abort_h = 1'b0;
        end_cycle();

        // Abort raised during FILL is ignored; full line still written to way 1.
        set_in(4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1, 4'b0000);
        push_exp(4'b0001, 1'b0, 1'b0, 2'd1, 4, 1, 0, 1);
        start(4'b0001);
        @(posedge clk_csh_h); #1;
        @(posedge clk_csh_h); #1;
        abort_h = 1'b1;
        wait_done("abort_fill", 20, lat);
        abort_h = 1'b0;
        end_cycle();

        // Reset mid-FILL clears everything without waiting for a clock.
        set_in(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1, 4'b0000);
        diag_rd_h = 1'b1;
        push_exp(4'b0010, 1'b0, 1'b0, 2'd3, 4, 1, 0, 1);
        start(4'b0010);
        @(posedge clk_csh_h); #1;
        @(posedge clk_csh_h); #1;
        check_eq("fill_active", 32'(cache_wr_h), 32'd1);
        #2 mr_reset_l = 1'b0;
        #1;
        check_eq("rst_async_outs", {8'd0, grant_h, cyc_busy_h, core_rd_rq_h, core_wr_rq_h, cache_wr_h,
                 way_sel_h, word_cnt_h, use_wr_en_h, done_h, hit_h, err_h, diag_data_h}, 32'd0);
        repeat (2) @(posedge clk_csh_h);
        @(negedge clk_csh_h);
        check_eq("rst_no_done", 32'(done_h), 32'd0);
        @(posedge clk_csh_h); #1;
        mr_reset_l = 1'b1;
        core_data_valid_h = 1'b0;
        repeat (3) @(posedge clk_csh_h);
        @(negedge clk_csh_h);
        check_eq("post_rst_idle", 32'(cyc_busy_h), 32'd0);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
